// File: rtl/incr_nx3_pipe_if.sv
// Valid/ready operand and result channels of the pipelined N x 3-bit incrementor.
// The slave modport is the incrementor side; the master modport is the producer/consumer side.
interface incr_nx3_pipe_if #(
    parameter int W = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_carry;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
endinterface

// File: rtl/incr_nx3_pipe.sv
// Two-stage pipelined incrementor built from 3-bit slices: stage 1 registers per-slice
// incremented/raw values and all-ones flags, stage 2 picks each slice via a prefix-AND carry.
module incr_nx3_pipe #(
    parameter int SLICES = 4
) (
    input logic            clk,
    input logic            rst,
    incr_nx3_pipe_if.slave bus
);
    localparam int W = 3 * SLICES;

    function automatic logic [2:0] incr3(input logic [2:0] x);
        return x + 3'd1;
    endfunction

    logic [W-1:0]      inc_p1;
    logic [W-1:0]      raw_p1;
    logic [SLICES-1:0] ones_p1;
    logic              vld_p1;

    logic [W-1:0]      data_p2;
    logic              carry_p2;
    logic              vld_p2;

    logic              s2_ready;
    logic              in_ready;
    logic              load_p1;
    logic              load_p2;

    logic [SLICES-1:0] sel;
    logic [W-1:0]      sum;
    logic              wrap;

    assign s2_ready = ~vld_p2 | bus.out_ready;
    assign in_ready = ~vld_p1 | s2_ready;
    assign load_p1  = bus.in_valid & in_ready;
    assign load_p2  = vld_p1 & s2_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p2;
    assign bus.out_data  = data_p2;
    assign bus.out_carry = carry_p2;

    // Stage 1: per-slice increment, pass-through and all-ones flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_p1  <= '0;
            raw_p1  <= '0;
            ones_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            // When in_ready is high stage 1 is either empty or draining this edge
            if (in_ready) begin
                vld_p1 <= bus.in_valid;
            end
            if (load_p1) begin
                for (int k = 0; k < SLICES; k++) begin
                    inc_p1[3*k +: 3] <= incr3(bus.in_data[3*k +: 3]);
                    raw_p1[3*k +: 3] <= bus.in_data[3*k +: 3];
                    ones_p1[k]       <= &bus.in_data[3*k +: 3];
                end
            end
        end
    end

    // Carry-select: slice k increments only if every lower slice is all ones
    always_comb begin
        sel    = '0;
        sel[0] = 1'b1;
        for (int k = 1; k < SLICES; k++) begin
            sel[k] = sel[k-1] & ones_p1[k-1];
        end
        sum = '0;
        for (int k = 0; k < SLICES; k++) begin
            sum[3*k +: 3] = sel[k] ? inc_p1[3*k +: 3] : raw_p1[3*k +: 3];
        end
        wrap = sel[SLICES-1] & ones_p1[SLICES-1];
    end

    // Stage 2: output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p2  <= '0;
            carry_p2 <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            if (s2_ready) begin
                vld_p2 <= vld_p1;
            end
            if (load_p2) begin
                data_p2  <= sum;
                carry_p2 <= wrap;
            end
        end
    end
endmodule

// File: tb/tb_incr_nx3_pipe.sv
// Scoreboard bench for incr_nx3_pipe: accepted operands push x+1 (with wrap carry) into a
// queue, an independent monitor pops and compares on every output transfer.
module tb_incr_nx3_pipe;
    localparam int SLICES = 4;
    localparam int W      = 3 * SLICES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    incr_nx3_pipe_if #(.W(W)) bus ();

    incr_nx3_pipe #(.SLICES(SLICES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [W:0] sb[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    // Reference: increment with the carry-out as the extra top bit
    function automatic logic [W:0] model(input logic [W-1:0] x);
        return {1'b0, x} + (W+1)'(1);
    endfunction

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic r,
                               output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        acc = v && bus.in_ready && !rst;
        if (acc) sb.push_back(model(d));
    endtask

    task automatic send(input logic [W-1:0] d, input bit rand_ready);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            drive_cycle(1'b1, d, rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        logic acc;
        int   cyc;
        cyc = 0;
        while ((sb.size() != 0 || bus.out_valid) && cyc < 50) begin
            drive_cycle(1'b0, '0, 1'b1, acc);
            cyc++;
        end
        drive_cycle(1'b0, '0, 1'b1, acc);
        drive_cycle(1'b0, '0, 1'b1, acc);
        check("sb_empty", (W+1)'(sb.size()), 0);
    endtask

    // Monitor: compare each output transfer and verify stability while stalled
    logic         prev_stall = 1'b0;
    logic [W:0]   prev_out   = '0;
    initial begin
        logic [W:0] cur;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                cur = {bus.out_carry, bus.out_data};
                if (prev_stall) begin
                    check("hold_valid", (W+1)'(bus.out_valid), 1);
                    check("hold_data", cur, prev_out);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) check("unexpected_out", cur, '1);
                    else check("result", cur, sb.pop_front());
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_out   = cur;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   accepts;
        int   k;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", (W+1)'(bus.out_valid), 0);
        check("rst_out_data", {bus.out_carry, bus.out_data}, 0);
        check("rst_in_ready", (W+1)'(bus.in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single operand latency
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1;
        check("t1_in_ready", (W+1)'(bus.in_ready), 1);
        if (bus.in_ready) sb.push_back(model('0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("t1_not_yet", (W+1)'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        check("t1_valid", (W+1)'(bus.out_valid), 1);
        check("t1_data", {bus.out_carry, bus.out_data}, 13'h0001);
        drain();

        // Carry chain across slices
        send(12'h0FF, 1'b0);
        send(12'h7FF, 1'b0);
        send(12'hFFF, 1'b0);
        send(12'h5B7, 1'b0);
        drain();

        // Back-to-back full stream
        accepts = 0;
        for (int i = 0; i < 4096; i++) begin
            drive_cycle(1'b1, W'(i), 1'b1, acc);
            if (acc) accepts++;
            else i--;
            if (accepts + 10 < i) break;
        end
        check("stream_accepts", (W+1)'(accepts), 4096);
        drain();

        // Backpressure with stream pending
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, W'(12'h100 + k), 1'b0, acc);
            if (acc) k++;
        end
        check("bp_accepts", (W+1)'(k), 2);
        check("bp_in_ready", (W+1)'(bus.in_ready), 0);
        while (k < 8) begin
            send(W'(12'h100 + k), 1'b0);
            k++;
        end
        drain();

        // Random traffic against the reference
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0)
                drive_cycle(1'b0, '0, $urandom_range(0, 3) != 0, acc);
            send(W'($urandom), 1'b1);
        end
        drain();

        // Reset with both stages occupied
        drive_cycle(1'b1, 12'h123, 1'b0, acc);
        drive_cycle(1'b1, 12'h456, 1'b0, acc);
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", (W+1)'(bus.out_valid), 0);
        check("rstmid_out_data", {bus.out_carry, bus.out_data}, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_in_ready", (W+1)'(bus.in_ready), 1);
        send(12'hABF, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
